// File: rtl/raw10_pkg.sv
// raw10_pkg: shared constants for the RAW10 transmit packer.
package raw10_pkg;
   localparam int BYTES_PER_GROUP = 5;
   localparam int PIX_PER_GROUP   = 4;
   localparam int BUF_DEPTH       = 8;
   localparam int READY_THRESH    = 3;
   localparam int PIX_STRIDE      = 16;
   localparam int PIX_BITS        = 10;
   function automatic int pix_lsb(input int k);
      return k * PIX_STRIDE;
   endfunction
endpackage

// File: rtl/raw10_group_pack.sv
// raw10_group_pack: four 10-bit pixels to five RAW10 stream bytes, B0 in bits [7:0].
module raw10_group_pack
   import raw10_pkg::*;
(
   input  logic [63:0] din,
   output logic [39:0] bytes_o
);
   logic unused_pad;
   assign unused_pad = ^{din[63:58], din[47:42], din[31:26], din[15:10]};
   for (genvar k = 0; k < PIX_PER_GROUP; k++) begin : g_pix
      assign bytes_o[8*k +: 8]    = din[pix_lsb(k) + 2 +: 8];
      assign bytes_o[32+2*k +: 2] = din[pix_lsb(k) +: 2];
   end
endmodule

// File: rtl/raw10_encoder.sv
// raw10_encoder: packs 4-pixel groups into the CSI-2 RAW10 stream, emitted as byte pairs.
// Define RAW10_ENC_ODD_PAD_EN to emit an odd line-final byte as a padded full word (dout_half tied 0).
module raw10_encoder
   import raw10_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   input  logic        din_last,
   output logic [15:0] dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        dout_last,
   output logic        dout_half
);
   logic [8*BUF_DEPTH-1:0]       buf_q, buf_d;
   logic [BUF_DEPTH-1:0]         last_q, last_d;
   logic [3:0]                   count_q, count_d, base;
   logic [1:0]                   pop;
   logic                         push;
   logic [8*BYTES_PER_GROUP-1:0] grp;

   raw10_group_pack u_pack (.din(din), .bytes_o(grp));

   assign din_ready  = count_q <= 4'(READY_THRESH);
   assign dout_valid = count_q >= 4'd2 || (count_q != 4'd0 && last_q[0]);
   assign dout       = {last_q[0] ? 8'h00 : buf_q[15:8], buf_q[7:0]};
   assign dout_last  = last_q[0] || (last_q[1] && count_q >= 4'd2);
`ifdef RAW10_ENC_ODD_PAD_EN
   assign dout_half  = 1'b0;
`else
   assign dout_half  = last_q[0];
`endif

   // Slots above count are always zero, so the shifted buffer can simply be OR-ed with the new group.
   always_comb begin
      push    = din_valid && din_ready;
      pop     = !(dout_valid && dout_ready) ? 2'd0 : last_q[0] ? 2'd1 : 2'd2;
      base    = count_q - {2'b00, pop};
      buf_d   = (buf_q >> {pop, 3'b000}) | (push ? {24'h0, grp} << {base, 3'b000} : '0);
      last_d  = (last_q >> pop) | (push ? {3'b000, din_last, 4'b0000} << base : '0);
      count_d = base + (push ? 4'(BYTES_PER_GROUP) : 4'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q   <= '0;
         last_q  <= '0;
         count_q <= '0;
      end else begin
         buf_q   <= buf_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_raw10_encoder.sv
// tb_raw10_encoder: scoreboard bench for raw10_encoder.
module tb_raw10_encoder;
   logic        clk = 1'b0;
   logic        reset, din_valid, din_ready, din_last;
   logic        dout_valid, dout_ready, dout_last, dout_half;
   logic [63:0] din;
   logic [15:0] dout;
   int          n_checks = 0, n_errors = 0;
   logic [17:0] exp_q[$], got_q[$];
   logic [8:0]  pend_q[$];
   logic [17:0] held;
   logic        stalled = 1'b0;

`ifdef RAW10_ENC_ODD_PAD_EN
   localparam logic HALF = 1'b0;
`else
   localparam logic HALF = 1'b1;
`endif

   always #5 clk = ~clk;

   raw10_encoder dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .din_last(din_last), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last), .dout_half(dout_half)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] pack(input logic [63:0] d);
      logic [39:0] r;
      for (int k = 0; k < 4; k++) begin
         r[8*k +: 8]    = d[16*k+2 +: 8];
         r[32+2*k +: 2] = d[16*k +: 2];
      end
      return r;
   endfunction

   function automatic logic [63:0] grp4(input logic [9:0] p0, p1, p2, p3);
      return {6'h0, p3, 6'h0, p2, 6'h0, p1, 6'h0, p0};
   endfunction

   // Expected words entry: {last, half, data}
   task automatic model_push(input logic [63:0] d, input logic l);
      logic [39:0] b;
      b = pack(d);
      for (int i = 0; i < 5; i++) pend_q.push_back({(i == 4) && l, b[8*i +: 8]});
      while (pend_q.size() != 0) begin
         if (pend_q[0][8]) begin
            exp_q.push_back({1'b1, HALF, 8'h00, pend_q[0][7:0]});
            void'(pend_q.pop_front());
         end else if (pend_q.size() >= 2) begin
            exp_q.push_back({pend_q[1][8], 1'b0, pend_q[1][7:0], pend_q[0][7:0]});
            void'(pend_q.pop_front());
            void'(pend_q.pop_front());
         end else break;
      end
   endtask

   task automatic step(input logic v, input logic [63:0] d, input logic l, input logic r);
      din = d; din_valid = v; din_last = l; dout_ready = r;
      #1;
      if (stalled) check("hold", {dout_valid, dout_last, dout_half, dout}, {1'b1, held});
      stalled = dout_valid && !dout_ready;
      held = {dout_last, dout_half, dout};
      if (dout_valid && dout_ready) begin
         got_q.push_back(held);
         check("sb_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("word", held, exp_q.pop_front());
      end
      if (din_valid && din_ready) model_push(d, l);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [63:0] d, input logic l, input int ready_pct);
      bit acc = 1'b0;
      for (int n = 0; n < 50 && !acc; n++) begin
         acc = din_ready;
         step(1'b1, d, l, $urandom_range(99) < ready_pct);
      end
      check("send_accept", acc, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || dout_valid) && n < 60) begin
         step(1'b0, '0, 1'b0, 1'b1);
         n++;
      end
      check("drain_done", exp_q.size() == 0 && !dout_valid && pend_q.size() == 0, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din = '0; din_last = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete(); pend_q.delete(); stalled = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] g8[8];
      logic [9:0]  rdy_pat;
      int          idx, vcnt;
      bit          acc;
      do_reset();
      check("rst_din_ready", din_ready, 1);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_dout_last", dout_last, 0);
      check("rst_dout_half", dout_half, 0);
      // single-group line with an odd byte count
      got_q.delete();
      step(1'b1, grp4(10'h3FF, 10'h000, 10'h2AA, 10'h155), 1'b1, 1'b1);
      drain();
      check("t1_words", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("t1_w0", got_q[0], {2'b00, 16'h00FF});
         check("t1_w1", got_q[1], {2'b00, 16'h55AA});
         check("t1_w2", got_q[2], {1'b1, HALF, 16'h0063});
      end
      // two back-to-back groups
      got_q.delete();
      send({$urandom, $urandom}, 1'b0, 100);
      send({$urandom, $urandom}, 1'b1, 100);
      drain();
      check("t2_words", got_q.size(), 5);
      if (got_q.size() == 5)
         for (int i = 0; i < 5; i++) begin
            check("t2_last", got_q[i][17], i == 4);
            check("t2_half", got_q[i][16], 0);
         end
      // sustained throughput
      got_q.delete();
      for (int i = 0; i < 8; i++) g8[i] = {$urandom, $urandom};
      idx = 0; vcnt = 0; rdy_pat = '0;
      for (int c = 0; c < 21; c++) begin
         if (c < 10) rdy_pat[c] = din_ready;
         if (c > 0) vcnt += int'(dout_valid);
         acc = din_ready && idx < 8;
         step(idx < 8, g8[idx[2:0]], idx == 7, 1'b1);
         if (acc) idx++;
      end
      check("t3_ready_pattern", rdy_pat, 10'b0010100101);
      check("t3_valid_cycles", vcnt, 20);
      check("t3_groups", idx, 8);
      check("t3_words", got_q.size(), 20);
      drain();
      // output stall mid-line
      send({$urandom, $urandom}, 1'b0, 100);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      check("t4_ready_low", din_ready, 0);
      check("t4_valid", dout_valid, 1);
      send({$urandom, $urandom}, 1'b1, 100);
      drain();
      // reset with six bytes buffered
      send({$urandom, $urandom}, 1'b0, 100);
      step(1'b0, '0, 1'b0, 1'b1);
      send({$urandom, $urandom}, 1'b0, 100);
      do_reset();
      check("t5_valid", dout_valid, 0);
      check("t5_ready", din_ready, 1);
      check("t5_dout", dout, 0);
      got_q.delete();
      send(grp4(10'h3FF, 10'h000, 10'h2AA, 10'h155), 1'b1, 100);
      drain();
      check("t5_words", got_q.size(), 3);
      if (got_q.size() != 0) check("t5_first", got_q[0], {2'b00, 16'h00FF});
      // random lines and backpressure
      for (int ln = 0; ln < 40; ln++) begin
         int n = $urandom_range(9, 1);
         for (int g = 0; g < n; g++) begin
            if ($urandom_range(3) == 0) step(1'b0, '0, 1'b0, $urandom_range(1));
            send({$urandom, $urandom}, g == n - 1, 60);
         end
      end
      drain();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
